soc_decerr_slave: RTL and testbench

SOC_DECERR_SLAVE -- requirements
Module: soc_decerr_slave

---
 rtl/soc_decerr_slave.sv | 182 ++++++++++++++++++
 tb/tb_soc_decerr_slave.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_decerr_slave.sv
// Default AXI responder for unmapped address space: every transaction completes with DECERR.
// It also records the first faulting address and counts completed DECERR transactions.
module soc_decerr_slave #(
  parameter int ID_W   = 8,
  parameter int DATA_W = 64
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  // AW
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ID_W-1:0]   s_awid,
  input  logic [31:0]       s_awaddr,
  input  logic [7:0]        s_awlen,
  // W
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic              s_wlast,
  // B
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [ID_W-1:0]   s_bid,
  output logic [1:0]        s_bresp,
  // AR
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [31:0]       s_araddr,
  input  logic [7:0]        s_arlen,
  // R
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ID_W-1:0]   s_rid,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  // status
  output logic              err_valid,
  output logic [31:0]       err_addr,
  output logic              err_is_wr,
  input  logic              err_clr,
  output logic [15:0]       dec_err_cnt
);

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  w_state_t        w_state, w_next;
  r_state_t        r_state, r_next;
  logic [ID_W-1:0] aw_id_q, ar_id_q;
  logic [7:0]      beat_cnt;

  logic aw_hs, ar_hs, b_hs, r_hs, r_last_hs;

  // Handshakes decoded from state rather than the ready outputs to keep the
  // next-state logic free of combinational feedback.
  assign aw_hs     = s_awvalid && (w_state == W_IDLE);
  assign ar_hs     = s_arvalid && (r_state == R_IDLE);
  assign b_hs      = s_bready  && (w_state == W_RESP);
  assign r_hs      = s_rready  && (r_state == R_DATA);
  assign r_last_hs = r_hs && (beat_cnt == 8'd0);

  // Burst length, write data and addresses outside the error capture are
  // intentionally ignored; only wlast ends a write burst.
  logic unused_ok;
  assign unused_ok = ^{s_awlen, s_wdata};

  // ---------------------------------------------------------------- write path
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (axi_rst) begin
      w_state <= W_IDLE;
      aw_id_q <= '0;
    end else begin
      w_state <= w_next;
      if (aw_hs) aw_id_q <= s_awid;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a variable unassigned and infers a latch.
    w_next    = w_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = 2'b00;
    case (w_state)
      W_IDLE: begin
        s_awready = 1'b1;
        if (s_awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) w_next = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        s_bresp  = RESP_DECERR;
        if (s_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign s_bid = aw_id_q;

  // ----------------------------------------------------------------- read path
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_state  <= R_IDLE;
      ar_id_q  <= '0;
      beat_cnt <= '0;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        ar_id_q  <= s_arid;
        beat_cnt <= s_arlen;
      end else if (r_hs && beat_cnt != 8'd0) begin
        beat_cnt <= beat_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    r_next    = r_state;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rresp   = 2'b00;
    s_rlast   = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        s_rresp  = RESP_DECERR;
        s_rlast  = (beat_cnt == 8'd0);
        if (s_rready && beat_cnt == 8'd0) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign s_rid   = ar_id_q;
  assign s_rdata = '0;

  // ------------------------------------------------------------- error status
  // A new fault is captured when nothing is held or when a clear arrives in the
  // same cycle; a simultaneous write takes priority over a read.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_is_wr <= 1'b0;
    end else if ((aw_hs || ar_hs) && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_is_wr <= aw_hs;
      err_addr  <= aw_hs ? s_awaddr : s_araddr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end

  logic [1:0]  cnt_inc;
  logic [16:0] cnt_sum;

  assign cnt_inc = {1'b0, b_hs} + {1'b0, r_last_hs};
  assign cnt_sum = {1'b0, dec_err_cnt} + {15'd0, cnt_inc};

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst)         dec_err_cnt <= '0;
    else if (cnt_sum[16]) dec_err_cnt <= 16'hFFFF;
    else                  dec_err_cnt <= cnt_sum[15:0];
  end

endmodule

// File: tb/tb_soc_decerr_slave.sv
// Directed bench for soc_decerr_slave with a response scoreboard fed at each
// address handshake and drained at each B/R handshake.
module tb_soc_decerr_slave;

  localparam int ID_W   = 8;
  localparam int DATA_W = 64;

  logic              axi_clk = 1'b0;
  logic              axi_rst;
  logic              s_awvalid, s_awready;
  logic [ID_W-1:0]   s_awid;
  logic [31:0]       s_awaddr;
  logic [7:0]        s_awlen;
  logic              s_wvalid, s_wready;
  logic [DATA_W-1:0] s_wdata;
  logic              s_wlast;
  logic              s_bvalid, s_bready;
  logic [ID_W-1:0]   s_bid;
  logic [1:0]        s_bresp;
  logic              s_arvalid, s_arready;
  logic [ID_W-1:0]   s_arid;
  logic [31:0]       s_araddr;
  logic [7:0]        s_arlen;
  logic              s_rvalid, s_rready;
  logic [ID_W-1:0]   s_rid;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              err_valid;
  logic [31:0]       err_addr;
  logic              err_is_wr;
  logic              err_clr;
  logic [15:0]       dec_err_cnt;

  soc_decerr_slave #(.ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .err_valid(err_valid), .err_addr(err_addr), .err_is_wr(err_is_wr),
    .err_clr(err_clr), .dec_err_cnt(dec_err_cnt)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            last;
  } r_exp_t;

  int unsigned     n_cmp = 0;
  int unsigned     n_err = 0;
  logic [ID_W-1:0] b_q[$];
  r_exp_t          r_q[$];
  int unsigned     w_hs_cnt = 0;
  int unsigned     r_beats  = 0;
  int unsigned     r_lasts  = 0;
  logic [16:0]     exp_cnt  = '0;
  logic            stalled  = 1'b0;
  logic [127:0]    held     = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_clk);
    #1;
  endtask

  // Scoreboard: expected responses are queued at address handshakes and
  // compared when the DUT completes them. Sampled on the falling edge.
  always @(negedge axi_clk) begin
    if (axi_rst) begin
      b_q.delete();
      r_q.delete();
      exp_cnt = '0;
      stalled = 1'b0;
    end else begin
      logic [1:0] inc;
      r_exp_t     e;
      inc = 2'd0;
      if (s_awvalid && s_awready) b_q.push_back(s_awid);
      if (s_arvalid && s_arready)
        for (int i = 0; i <= int'(s_arlen); i++)
          r_q.push_back('{id: s_arid, last: (i == int'(s_arlen))});
      if (s_wvalid && s_wready) w_hs_cnt++;
      if (s_bvalid && s_bready) begin
        if (b_q.size() == 0) check("b_unexpected", 1, 0);
        else begin
          check("bid", s_bid, b_q.pop_front());
          check("bresp", s_bresp, 2'b11);
        end
        inc++;
      end
      if (stalled) check("r_stable", {s_rvalid, s_rid, s_rlast, s_rresp, s_rdata}, held);
      if (s_rvalid && s_rready) begin
        r_beats++;
        if (s_rlast) r_lasts++;
        if (r_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          e = r_q.pop_front();
          check("rid", s_rid, e.id);
          check("rdata", s_rdata, 0);
          check("rresp", s_rresp, 2'b11);
          check("rlast", s_rlast, e.last);
          if (e.last) inc++;
        end
      end
      stalled = s_rvalid && !s_rready;
      held    = {s_rvalid, s_rid, s_rlast, s_rresp, s_rdata};
      exp_cnt = exp_cnt + {15'd0, inc};
      if (exp_cnt > 17'h0FFFF) exp_cnt = 17'h0FFFF;
    end
  end

  initial begin
    int unsigned base, guard;
    axi_rst = 1'b1;
    {s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready, err_clr} = '0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_wdata = '0;
    s_arid = '0; s_araddr = '0; s_arlen = '0;
    #1;
    // Reset values
    check("rst_ready", {s_awready, s_arready, s_wready, s_bvalid, s_rvalid, s_rlast}, 6'b110000);
    check("rst_ids", {s_bid, s_rid, s_bresp, s_rresp}, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_err", {err_valid, err_addr, err_is_wr, dec_err_cnt}, 0);
    repeat (2) step();
    axi_rst = 1'b0;
    step();

    // Write burst: early W beat is refused, four beats, then DECERR on B
    s_awvalid = 1; s_awid = 8'h5A; s_awaddr = 32'h1100_0000; s_awlen = 8'd3;
    s_wvalid = 1; s_wdata = 64'hDEAD_BEEF;
    check("w_before_aw", s_wready, 0);
    step();
    s_awvalid = 0;
    for (int i = 0; i < 4; i++) begin
      s_wlast = (i == 3);
      check("w_ready", s_wready, 1);
      step();
    end
    s_wvalid = 0; s_wlast = 0;
    check("w_hs_cnt", w_hs_cnt, 4);
    check("b_valid", {s_bvalid, s_bid, s_bresp, s_awready, s_wready}, {1'b1, 8'h5A, 2'b11, 1'b0, 1'b0});
    step();
    check("b_held", {s_bvalid, s_bid}, {1'b1, 8'h5A});
    s_bready = 1;
    step();
    s_bready = 0;
    check("b_done", {s_bvalid, s_awready}, 2'b01);
    check("cnt_1", dec_err_cnt, 1);
    check("err_wr", {err_valid, err_addr, err_is_wr}, {1'b1, 32'h1100_0000, 1'b1});

    // Read burst len 7 with rready held high
    s_arvalid = 1; s_arid = 8'h03; s_araddr = 32'h2000_0000; s_arlen = 8'd7; s_rready = 1;
    step();
    s_arvalid = 0;
    base = r_beats;
    for (int i = 0; i < 8; i++) begin
      check("r8_valid", {s_rvalid, s_rlast}, {1'b1, (i == 7)});
      step();
    end
    check("r8_beats", r_beats - base, 8);
    check("r8_idle", {s_rvalid, s_arready}, 2'b01);
    check("cnt_2", dec_err_cnt, 2);
    check("err_kept", {err_addr, err_is_wr}, {32'h1100_0000, 1'b1});

    // Read burst len 255 with rready toggling every cycle
    s_arvalid = 1; s_arid = 8'h77; s_arlen = 8'd255; s_rready = 0;
    step();
    s_arvalid = 0;
    base = r_beats;
    guard = 0;
    while (r_beats - base < 256 && guard < 2000) begin
      s_rready = guard[0];
      guard++;
      step();
    end
    s_rready = 0;
    step();
    check("r256_timeout", guard < 2000, 1);
    check("r256_beats", r_beats - base, 256);
    check("r256_lasts", r_lasts, 2);
    check("r256_idle", s_rvalid, 0);
    check("cnt_3", dec_err_cnt, 3);

    // Clear, then simultaneous AW and AR; B and last R complete together
    err_clr = 1;
    step();
    err_clr = 0;
    check("err_cleared", err_valid, 0);
    s_awvalid = 1; s_awid = 8'h11; s_awaddr = 32'hF800_0000; s_awlen = 8'd0;
    s_arvalid = 1; s_arid = 8'h22; s_araddr = 32'h1200_0000; s_arlen = 8'd0;
    step();
    s_awvalid = 0; s_arvalid = 0;
    check("err_both", {err_valid, err_addr, err_is_wr}, {1'b1, 32'hF800_0000, 1'b1});
    s_wvalid = 1; s_wlast = 1;
    step();
    s_wvalid = 0; s_wlast = 0;
    check("both_pending", {s_bvalid, s_rvalid, s_rlast}, 3'b111);
    s_bready = 1; s_rready = 1;
    step();
    s_bready = 0; s_rready = 0;
    check("cnt_plus2", dec_err_cnt, 5);

    // Reset during beat 3 of 8
    s_arvalid = 1; s_arid = 8'h09; s_arlen = 8'd7; s_rready = 1;
    step();
    s_arvalid = 0;
    step();
    step();
    axi_rst = 1;
    #1;
    check("rst_mid_burst", {s_rvalid, s_arready, s_rlast, s_rid}, {1'b0, 1'b1, 1'b0, 8'h00});
    base = r_beats;
    repeat (2) step();
    axi_rst = 0;
    repeat (5) step();
    check("no_beats_after_rst", r_beats - base, 0);
    check("rst_state", {s_rvalid, err_valid, dec_err_cnt}, 0);
    s_rready = 0;

    // Run continuous write and read traffic to bring the counter near its limit
    s_awvalid = 1; s_awid = 8'h44; s_awaddr = 32'hA000_0000;
    s_wvalid = 1; s_wlast = 1; s_bready = 1;
    s_arvalid = 1; s_arid = 8'h55; s_araddr = 32'hB000_0000; s_arlen = 8'd0; s_rready = 1;
    guard = 0;
    while (exp_cnt < 17'h0FFF0 && guard < 90000) begin
      guard++;
      step();
    end
    s_awvalid = 0; s_arvalid = 0;
    repeat (8) step();
    s_wvalid = 0; s_wlast = 0;
    check("grind_timeout", guard < 90000, 1);
    guard = 0;
    while (exp_cnt < 17'h0FFFE && guard < 100) begin
      s_arvalid = 1;
      step();
      s_arvalid = 0;
      step();
      guard++;
    end
    check("preload_timeout", guard < 100, 1);
    check("cnt_fffe", dec_err_cnt, 16'hFFFE);
    check("err_grind", {err_valid, err_addr, err_is_wr}, {1'b1, 32'hA000_0000, 1'b1});

    // Two back-to-back completions at 0xFFFE: saturate and hold
    for (int i = 0; i < 2; i++) begin
      s_arvalid = 1;
      step();
      s_arvalid = 0;
      step();
      check("cnt_sat", dec_err_cnt, 16'hFFFF);
    end

    // err_clr coincident with a new AR: capture wins
    s_arvalid = 1; s_arid = 8'h66; s_araddr = 32'h1300_0000; err_clr = 1;
    step();
    s_arvalid = 0; err_clr = 0;
    check("clr_vs_capture", {err_valid, err_addr, err_is_wr}, {1'b1, 32'h1300_0000, 1'b0});
    step();
    check("cnt_hold", dec_err_cnt, 16'hFFFF);
    check("queues_empty", {b_q.size() == 0, r_q.size() == 0}, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
